// File: rtl/vga_pkg.sv
// Shared VGA definitions: display defaults, RGB565 colours and the screen-state
// encoding decoded by both the sequencer and the game logic.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_V_DISPLAY = 480;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN  = 16'h07E0;

  typedef enum logic [2:0] {
    SCR_START   = 3'd0,
    SCR_BLANK_P = 3'd1,
    SCR_PLAY    = 3'd2,
    SCR_BLANK_E = 3'd3,
    SCR_END     = 3'd4
  } scr_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Signal bundle between the VGA controller side (master) and the screen sequencer (slave).
interface screen_sequencer_if;

  // No valid/ready handshake: pix_x/pix_y and the sources are sampled every cycle,
  // start_req/game_over are one-cycle pulses, and all outputs are valid every cycle.
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        start_req;
  logic        game_over;
  logic [15:0] start_pix;
  logic [15:0] game_pix;
  logic [15:0] end_pix;
  logic [15:0] pix_data;
  logic [2:0]  scr_state;
  logic        game_en;
  logic        end_active;

  modport master (
    output pix_x, pix_y, start_req, game_over, start_pix, game_pix, end_pix,
    input  pix_data, scr_state, game_en, end_active
  );

  modport slave (
    input  pix_x, pix_y, start_req, game_over, start_pix, game_pix, end_pix,
    output pix_data, scr_state, game_en, end_active
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame strobe on the last active pixel of the frame.
module frame_tick_gen #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480
) (
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       tick_o
);

  assign tick_o = (pix_x_i == 10'(H_DISPLAY - 1)) && (pix_y_i == 10'(V_DISPLAY - 1));

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen scheduler: START -> BLANK_P -> PLAY -> BLANK_E -> END -> START,
// owning the single registered pixel output to the VGA controller.
module screen_sequencer
  import vga_pkg::*;
#(
  parameter int H_DISPLAY      = VGA_H_DISPLAY,
  parameter int V_DISPLAY      = VGA_V_DISPLAY,
  parameter int BLANK_FRAMES   = 2,
  parameter int END_MIN_FRAMES = 120
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  screen_sequencer_if.slave  bus
);

  localparam int CNT_MAX = max_int(BLANK_FRAMES, END_MIN_FRAMES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_MIN_FRAMES - 1);
  // Saturate at the larger terminal count so a long blank run still reaches its exit value.
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX - 1);

  scr_state_e       state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             start_pend_q, start_pend_d;
  logic             over_pend_q, over_pend_d;
  logic [15:0]      pix_data_q, pix_data_d;
  logic             game_en_q, game_en_d;
  logic             end_active_q, end_active_d;
  logic             tick;
  logic             active;
  logic             consume_start;
  logic             consume_over;

  frame_tick_gen #(
    .H_DISPLAY (H_DISPLAY),
    .V_DISPLAY (V_DISPLAY)
  ) u_tick (
    .pix_x_i (bus.pix_x),
    .pix_y_i (bus.pix_y),
    .tick_o  (tick)
  );

  assign active = (bus.pix_x < 10'(H_DISPLAY)) && (bus.pix_y < 10'(V_DISPLAY));

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q      <= SCR_START;
      frame_cnt_q  <= '0;
      start_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      pix_data_q   <= BLACK;
      game_en_q    <= 1'b0;
      end_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      start_pend_q <= start_pend_d;
      over_pend_q  <= over_pend_d;
      pix_data_q   <= pix_data_d;
      game_en_q    <= game_en_d;
      end_active_q <= end_active_d;
    end
  end

  // Transitions only on the frame tick; only flags pending before this edge are consumed.
  always_comb begin
    state_d       = state_q;
    consume_start = 1'b0;
    consume_over  = 1'b0;
    if (tick) begin
      case (state_q)
        SCR_START: begin
          if (start_pend_q) begin
            state_d       = SCR_BLANK_P;
            consume_start = 1'b1;
          end
        end
        SCR_BLANK_P: begin
          if (frame_cnt_q == BLANK_LAST) state_d = SCR_PLAY;
        end
        SCR_PLAY: begin
          if (over_pend_q) begin
            state_d      = SCR_BLANK_E;
            consume_over = 1'b1;
          end
        end
        SCR_BLANK_E: begin
          if (frame_cnt_q == BLANK_LAST) state_d = SCR_END;
        end
        SCR_END: begin
          if (start_pend_q && (frame_cnt_q >= END_LAST)) begin
            state_d       = SCR_START;
            consume_start = 1'b1;
          end
        end
        default: state_d = SCR_START;
      endcase
    end
  end

  always_comb begin
    start_pend_d = (start_pend_q & ~consume_start)
                 | (bus.start_req & ((state_q == SCR_START) || (state_q == SCR_END)));
    over_pend_d  = (over_pend_q & ~consume_over)
                 | (bus.game_over & (state_q == SCR_PLAY));

    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (tick && (state_q inside {SCR_BLANK_P, SCR_BLANK_E, SCR_END})
                 && (frame_cnt_q != CNT_SAT)) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  // The pixel follows the pre-edge state, so the tick pixel still belongs to the old screen.
  always_comb begin
    game_en_d    = (state_d == SCR_PLAY);
    end_active_d = (state_d == SCR_END);
    pix_data_d   = BLACK;
    if (active) begin
      case (state_q)
        SCR_START: pix_data_d = bus.start_pix;
        SCR_PLAY:  pix_data_d = bus.game_pix;
        SCR_END:   pix_data_d = bus.end_pix;
        default:   pix_data_d = BLACK;
      endcase
    end
  end

  assign bus.pix_data   = pix_data_q;
  assign bus.scr_state  = state_q;
  assign bus.game_en    = game_en_q;
  assign bus.end_active = end_active_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: pixel-counter driver, frame-level reference model,
// expected queue consumed by an independent monitor.
module tb_screen_sequencer;
  import vga_pkg::*;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int BF    = 2;
  localparam int EMF   = 3;
  localparam int H_TOT = H + 2;
  localparam int V_TOT = V + 2;
  localparam int FRAME = H_TOT * V_TOT;

  logic vga_clk = 1'b0;
  logic sys_rst_n;

  screen_sequencer_if bus ();

  screen_sequencer #(
    .H_DISPLAY      (H),
    .V_DISPLAY      (V),
    .BLANK_FRAMES   (BF),
    .END_MIN_FRAMES (EMF)
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 vga_clk = ~vga_clk;

  // ---------------- reference model state ----------------
  int   px = 0;
  int   py = 0;
  int   m_state = 0;
  int   m_frames = 0;   // completed frames of the current screen
  bit   m_spend = 1'b0;
  bit   m_opend = 1'b0;
  logic [15:0] start_val = 16'hAAAA;

  logic [18:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cycle_no = 0;

  task automatic model_step(input bit tick, input bit sreq, input bit gov, input bit rst_n);
    int nxt;
    bit s_used;
    bit o_used;
    if (!rst_n) begin
      m_state = 0; m_frames = 0; m_spend = 1'b0; m_opend = 1'b0;
      return;
    end
    nxt = m_state; s_used = 1'b0; o_used = 1'b0;
    if (tick) begin
      case (m_state)
        0: if (m_spend) begin nxt = 1; s_used = 1'b1; end
        1: if (m_frames + 1 >= BF) nxt = 2;
        2: if (m_opend) begin nxt = 3; o_used = 1'b1; end
        3: if (m_frames + 1 >= BF) nxt = 4;
        4: if (m_spend && (m_frames + 1 >= EMF)) begin nxt = 0; s_used = 1'b1; end
        default: nxt = 0;
      endcase
    end
    if (s_used) m_spend = 1'b0;
    if (o_used) m_opend = 1'b0;
    if (sreq && (m_state == 0 || m_state == 4)) m_spend = 1'b1;
    if (gov && m_state == 2) m_opend = 1'b1;
    if (nxt != m_state) begin
      m_state  = nxt;
      m_frames = 0;
    end else if (tick) begin
      m_frames++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit sreq, input bit gov, input bit rst_n);
    logic [15:0] gp;
    logic [15:0] ep;
    logic [15:0] exp_pix;
    bit active;
    bit tick;
    @(negedge vga_clk);
    gp = 16'($urandom);
    ep = 16'($urandom);
    sys_rst_n     = rst_n;
    bus.pix_x     = 10'(px);
    bus.pix_y     = 10'(py);
    bus.start_req = sreq;
    bus.game_over = gov;
    bus.start_pix = start_val;
    bus.game_pix  = gp;
    bus.end_pix   = ep;
    active = (px < H) && (py < V);
    tick   = (px == H - 1) && (py == V - 1);
    exp_pix = 16'h0000;
    if (rst_n && active) begin
      case (m_state)
        0: exp_pix = start_val;
        2: exp_pix = gp;
        4: exp_pix = ep;
        default: exp_pix = 16'h0000;
      endcase
    end
    model_step(tick, sreq, gov, rst_n);
    exp_q.push_back({exp_pix, 3'(m_state)});
    px++;
    if (px == H_TOT) begin
      px = 0;
      py = (py + 1) % V_TOT;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic frames(input int n);
    idle(n * FRAME);
  endtask

  task automatic goto_pix(input int x, input int y);
    for (int i = 0; i < FRAME && !(px == x && py == y); i++) drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
    end
  endtask

  initial begin : monitor
    logic [18:0] e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", bus.pix_data, e[18:3]);
        check("scr_state", 16'(bus.scr_state), 16'(e[2:0]));
        check("game_en", 16'(bus.game_en), 16'(e[2:0] == 3'd2));
        check("end_active", 16'(bus.end_active), 16'(e[2:0] == 3'd4));
        cycle_no++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    sys_rst_n     = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.start_req = 1'b0;
    bus.game_over = 1'b0;
    bus.start_pix = '0;
    bus.game_pix  = '0;
    bus.end_pix   = '0;

    // Reset, then idle start screen
    drive_cycle(1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    frames(3);

    // Start request mid-frame: two black frames, then PLAY
    goto_pix(3, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(3);

    // game_over and start_req together in PLAY: only game_over counts; END then holds
    goto_pix(2, 2);
    drive_cycle(1'b1, 1'b1, 1'b1);
    frames(6);

    // Restart after the dwell has elapsed
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(2);

    // Back to PLAY, then into END, restart requested in the first END frame
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(3);
    goto_pix(1, 1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    goto_pix(H - 1, V - 1);
    idle(1);
    frames(2);
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(4);

    // game_over exactly on the PLAY tick: takes effect one frame later
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(3);
    goto_pix(H - 1, V - 1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    frames(5);
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(1);

    // Mid-line reset in PLAY discards a pending game_over
    goto_pix(1, 1);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(3);
    goto_pix(4, 2);
    drive_cycle(1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b0);
    frames(2);
    goto_pix(2, 0);
    drive_cycle(1'b1, 1'b0, 1'b1);
    frames(5);

    // Randomised traffic with occasional resets and random start-screen pixels
    for (int i = 0; i < 3000; i++) begin
      start_val = 16'($urandom);
      drive_cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 999) != 0);
    end

    repeat (2) @(posedge vga_clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
